// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX stage and the divider.
// master = EX stage (drives operands, start and flush), slave = div_unit.
interface div_unit_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        done_o;

  modport master (
    output start_i, signed_i, data1_i, data2_i, annul_i,
    input  result_o, done_o
  );

  modport slave (
    input  start_i, signed_i, data1_i, data2_i, annul_i,
    output result_o, done_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu.
// result_o = {remainder, quotient}; done_o stays high until EX drops start_i.
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the
// result is produced after one cycle instead of 32 iterations.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start_i; operands are captured on leaving
// S_DIVZERO | one-cycle short path (divide by zero, or early-out)
// S_ON      | one restoring iteration per cycle, 32 in total
// S_END     | result valid, held until start_i is released
module div_unit (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] d1_q, d1_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [64:0] work_q, work_d;
  logic [63:0] result_q, result_d;
  logic        done_q, done_d;

  logic [31:0] abs1, abs2;
  logic [64:0] shifted;
  logic [33:0] trial;
  logic [64:0] step;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes; |-2^31| wraps to 0x8000_0000, read as unsigned.
  always_comb begin
    abs1 = (bus.signed_i && bus.data1_i[31]) ? (~bus.data1_i + 32'd1) : bus.data1_i;
    abs2 = (bus.signed_i && bus.data2_i[31]) ? (~bus.data2_i + 32'd1) : bus.data2_i;
  end

  // One restoring step on the work register, plus the final sign fixups.
  // work_q[64] is always zero between steps; it is kept as the trial's top
  // bit so the subtraction sees the full shifted partial remainder.
  always_comb begin
    shifted = {work_q[63:0], 1'b0};
    trial   = {work_q[64], shifted[64:32]} - {2'b00, dvs_q};
    step    = trial[33] ? shifted : {trial[32:0], shifted[31:1], 1'b1};
    quo_fix = negq_q ? (~step[31:0] + 32'd1)  : step[31:0];
    rem_fix = negr_q ? (~step[63:32] + 32'd1) : step[63:32];
  end

  // Next-state and output logic; annul overrides every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d1_d     = d1_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    work_d   = work_q;
    result_d = result_q;
    done_d   = done_q;

    if (bus.annul_i) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            d1_d   = bus.data1_i;
            dvs_d  = abs2;
            negq_d = bus.signed_i & (bus.data1_i[31] ^ bus.data2_i[31]);
            negr_d = bus.signed_i & bus.data1_i[31];
            work_d = {33'b0, abs1};
            cnt_d  = '0;
            if (bus.data2_i == 32'd0)
              state_d = S_DIVZERO;
`ifdef DIV_EARLY_OUT_EN
            else if (abs1 < abs2)
              state_d = S_DIVZERO;
`endif
            else
              state_d = S_ON;
          end
        end
        S_DIVZERO: begin
          // A zero captured divisor means divide-by-zero; otherwise this is
          // the early-out path where the quotient is 0 and the remainder is
          // the raw dividend.
          result_d = {d1_q, (dvs_q == 32'd0) ? 32'hFFFF_FFFF : 32'h0000_0000};
          done_d   = 1'b1;
          state_d  = S_END;
        end
        S_ON: begin
          work_d = step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_d = {rem_fix, quo_fix};
            done_d   = 1'b1;
            state_d  = S_END;
          end
        end
        S_END: begin
          if (!bus.start_i) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = '0;
          end
        end
        default: begin
          state_d  = S_IDLE;
          done_d   = 1'b0;
          result_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      d1_q     <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d1_q     <= d1_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      work_q   <= work_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expected results come from
// plain integer arithmetic, the monitor checks each rising done_o.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return 1;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
`ifdef DIV_EARLY_OUT_EN
    if (sa < sb) return 1;
`endif
    return 32;
  endfunction

  // Monitor: every rising done_o must match the oldest outstanding request.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.done_o && !done_prev) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_done: done_o=1 result_o=%h, required no completion", bus.result_o);
        end else begin
          e = sb_q.pop_front();
          if (bus.result_o !== e.res) begin
            miscompares++;
            $display("FAIL result: got %h, required %h", bus.result_o, e.res);
          end
          vectors++;
          if (cyc - e.e0 != e.lat) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - e.e0, e.lat);
          end
        end
      end
      done_prev = rst ? 1'b0 : bus.done_o;
    end
  end

  task automatic check_idle(input string name);
    vectors++;
    if (bus.done_o !== 1'b0 || bus.result_o !== 64'd0) begin
      miscompares++;
      $display("FAIL %s: done_o=%b result_o=%h, required done_o=0 result_o=0", name, bus.done_o, bus.result_o);
    end
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.signed_i = sgn;
    bus.data1_i  = a;
    bus.data2_i  = b;
    bus.start_i  = 1'b1;
    e.res = ref_div(sgn, a, b);
    e.lat = ref_lat(sgn, a, b);
    e.e0  = cyc + 1;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.data1_i  = $urandom;
      bus.data2_i  = $urandom;
      bus.signed_i = 1'($urandom_range(0, 1));
    end while (!bus.done_o && n < 80);
    if (!bus.done_o) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: done_o still 0 after %0d cycles, required completion", n);
      sb_q.delete();
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        vectors++;
        if (bus.done_o !== 1'b1 || bus.result_o !== e.res) begin
          miscompares++;
          $display("FAIL hold: done_o=%b result_o=%h, required done_o=1 result_o=%h", bus.done_o, bus.result_o, e.res);
        end
      end
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    check_idle("release");
  endtask

  initial begin
    int sel;
    logic [31:0] a, b;
    #400_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int sel;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.data1_i  = '0;
    bus.data2_i  = '0;
    bus.annul_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 2);
    run_op(1'b1, -32'sd7, 32'd2, 0);
    run_op(1'b1, 32'd7, -32'sd2, 1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(1'b0, 32'h0000_1234, 32'd0, 1);
    run_op(1'b0, 32'd5, 32'd9, 0);
    run_op(1'b1, -32'sd5, 32'd9, 0);
    run_op(1'b1, 32'h8000_0000, 32'd1, 0);

    // Annul at iteration 10 of 1000 / 3.
    @(negedge clk);
    bus.signed_i = 1'b0; bus.data1_i = 32'd1000; bus.data2_i = 32'd3; bus.start_i = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    check_idle("annul");
    repeat (40) @(negedge clk);
    check_idle("annul_quiet");
    run_op(1'b0, 32'd9, 32'd3, 1);

    // start together with annul in IDLE must not launch a division.
    @(negedge clk);
    bus.data1_i = 32'd50; bus.data2_i = 32'd5; bus.start_i = 1'b1; bus.annul_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check_idle("start_with_annul");

    // Reset mid-iteration abandons the operation.
    @(negedge clk);
    bus.data1_i = 32'd77; bus.data2_i = 32'd5; bus.start_i = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset_mid_op");
    repeat (40) @(negedge clk);
    check_idle("reset_quiet");

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 4);
      a = $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = $urandom;
        3: b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd1;
        default: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 40)); end
      endcase
      run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 integer divider with its own sequencing FSM, shared by the EX stage for `div.w`, `div.wu`, `mod.w` and `mod.wu`. EX drives operands and a level `start_i` and stalls the pipeline until `done_o`. It then takes the quotient from `result_o[31:0]` and the remainder from `result_o[63:32]`. A flush from the pipeline control annuls an in-flight division.

## Interface
- No parameters; data width fixed at 32.
- `clk  in  1  rising-edge clock`
- `rst  in  1  reset; synchronous, active-high`
- `start_i  in  1  division request, level; held high by EX until done_o seen`
- `signed_i  in  1  1 = two's-complement operands, 0 = unsigned`
- `data1_i  in  32  dividend`
- `data2_i  in  32  divisor`
- `annul_i  in  1  flush; abandons current operation`
- `result_o  out  64  {remainder, quotient}; registered`
- `done_o  out  1  result valid; registered`

## Operation
- FSM states:
  - IDLE: accepts a request.
  - DIVZERO: divide-by-zero handling.
  - ON: iterating.
  - END: result valid, waiting for release.
- Operand capture:
  - Operands and `signed_i` are latched only on the IDLE→ON or IDLE→DIVZERO transition.
  - Input changes after that transition are ignored.
- IDLE:
  - `start_i=1` and `data2_i==0` → DIVZERO.
  - `start_i=1` and `data2_i!=0` → ON.
  - On the ON transition, latch |dividend| and |divisor| (magnitudes only when `signed_i`), plus `neg_q = signed & (d1[31]^d2[31])` and `neg_r = signed & d1[31]`.
  - Clear the 65-bit work register {rem[32:0], quo[31:0]} to {33'b0, |d1|}; clear the iteration counter `cnt` to 0.
- ON (restoring algorithm), once per cycle:
  - Shift the work register left by 1.
  - Compute trial = rem − {1'b0,|d2|}.
  - If trial ≥ 0, set rem = trial and quo[0] = 1; otherwise quo[0] = 0.
  - Increment `cnt`.
  - On the iteration where `cnt` reaches 32:
    - Apply sign fixups: quotient is negated when `neg_q`; remainder is negated when `neg_r`.
    - Write `result_o`, set `done_o=1`, go to END.
- DIVZERO: after one cycle, `result_o = {data1 latched, 32'hFFFF_FFFF}`, `done_o=1`, go to END.
- END:
  - `result_o` and `done_o` are held while `start_i=1`.
  - When `start_i=0`, go to IDLE with `done_o=0` and `result_o=0`.
- Arithmetic rules:
  - The magnitude of −2^31 is 0x8000_0000, treated as unsigned.
  - −2^31 / −1 → quotient 0x8000_0000 (negation wraps), remainder 0.
  - Remainder always takes the dividend's sign; |remainder| < |divisor|.
- Priority, highest first: `rst` > `annul_i` > FSM transitions.
- Annul:
  - `annul_i=1` in any state → IDLE, `done_o=0`, `result_o=0`.
  - The work register and counter are don't-care after annul.
  - `start_i=1` together with `annul_i=1` in IDLE does not start a division.

## Timing
- Reset: state IDLE, `done_o=0`, `result_o=0`, `cnt=0`, and all latched operands 0.
- Let E0 be the edge that samples `start_i=1` in IDLE.
- Normal division:
  - Iterations run at E1..E32.
  - `done_o` is high and `result_o` is valid after E32, i.e. a latency of 32 cycles after E0.
- Divide by zero: `done_o` is high after E1.
- Release: `start_i` is sampled low in END at edge Ek, and `done_o` falls after Ek. The earliest next acceptance is at Ek+1.
- Back-to-back requests: EX must drop `start_i` for at least one cycle between operations. `start_i` remaining high in END never restarts a division.
- Reset or annul mid-ON: takes effect at that edge; `done_o` is never asserted for the abandoned operation.

## Configuration
- `DIV_EARLY_OUT_EN`:
  - Defined: in IDLE with divisor ≠ 0 and |dividend| < |divisor|, the FSM goes directly to END after one cycle. The result is quotient 0, remainder = `data1_i` unchanged (sign preserved), so `done_o` rises after E1.
  - Undefined: every nonzero-divisor operation takes the full 32 iterations.
- The result values are identical in both builds; only the latency differs.

## Test plan
- Unsigned 100 / 7, `signed_i=0` → after 32 cycles `result_o[31:0]=14`, `[63:32]=2`, `done_o=1`. `done_o` holds until `start_i` drops, then clears the next cycle.
- Signed −7 / 2 → quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1). Signed 7 / −2 → quotient −3, remainder 1.
- Signed 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. Unsigned 0xFFFF_FFFF / 1 → quotient 0xFFFF_FFFF, remainder 0.
- Divide by zero, 0x1234 / 0 → `done_o` after 1 cycle with `result_o = {0x0000_1234, 0xFFFF_FFFF}`.
- Annul at iteration 10 of 1000 / 3 → `done_o` stays 0 and the FSM returns to IDLE. A fresh 9 / 3 request issued after `start_i` has been low for one cycle → quotient 3, remainder 0 after 32 cycles.
- `DIV_EARLY_OUT_EN` defined, 5 / 9 → `done_o` after E1 with quotient 0, remainder 5. Undefined → the same result after 32 cycles.
